tabela_sweep_checker: RTL

Self-checking stimulus/response stage wrapped around the 3-input truth-table block. On a start pulse it drives `x`, `y`, `z` through all eight combinations 000→111 into the truth-table block, samples the returned `s` for each, and builds the observed 8-entry table. It compares that table against a parameterised expected table and reports pass/fail, the mismatch count and the first failing index. It replaces the hand-written delay sweep with a clocked, reusable checker.

---
 rtl/tabela_sweep_checker_if.sv | 44 ++++
 rtl/tabela_sweep_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tabela_sweep_checker_if.sv
// Bundle between the sweep checker and the block under test / controlling logic.
// The checker uses the master modport; the environment uses the slave modport.
`timescale 1ns/1ps
interface tabela_sweep_checker_if;
    logic       start;
    logic       x;
    logic       y;
    logic       z;
    logic       s;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [3:0] err_count;
    logic [2:0] first_fail;

    modport master (
        input  start,
        input  s,
        output x,
        output y,
        output z,
        output busy,
        output done,
        output pass,
        output table_out,
        output err_count,
        output first_fail
    );

    modport slave (
        output start,
        output s,
        input  x,
        input  y,
        input  z,
        input  busy,
        input  done,
        input  pass,
        input  table_out,
        input  err_count,
        input  first_fail
    );
endinterface

// File: rtl/tabela_sweep_checker.sv
// Clocked sweep of a 3-input truth-table block: drives all eight {x,y,z} vectors,
// captures s for each and compares the observed table against EXPECTED.
`timescale 1ns/1ps
module tabela_sweep_checker #(
    parameter logic [7:0]  EXPECTED = 8'h2A,
    parameter int unsigned SETTLE   = 1
) (
    input logic                    clk,
    input logic                    reset,
    tabela_sweep_checker_if.master bus
);

    typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] table_q, table_d;
    logic [3:0] err_q, err_d;
    logic [2:0] first_q, first_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        table_d = table_q;
        err_d   = err_q;
        first_d = first_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWait;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    pass_d  = 1'b0;
                    table_d = 8'h00;
                    err_d   = 4'd0;
                    first_d = 3'd0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                table_d[idx_q] = bus.s;
                if (bus.s != EXPECTED[idx_q]) begin
                    err_d = err_q + 4'd1;
                    // Only the lowest failing index is kept.
                    if (err_q == 4'd0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == 3'd7) begin
                    state_d = StDone;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d = StWait;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the next state so nothing is combinational.
        stim_d = (state_d == StIdle) ? 3'd0 : idx_d;
        busy_d = (state_d == StWait) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            stim_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            table_q <= 8'h00;
            err_q   <= 4'd0;
            first_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            table_q <= table_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign bus.x          = stim_q[2];
    assign bus.y          = stim_q[1];
    assign bus.z          = stim_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.table_out  = table_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_q;

endmodule
